rle_encoder: RTL and testbench

//  Run-length encoder between the capture front end and the write path into the

---
 rtl/rle_encoder_pkg.sv | 15 +
 rtl/rle_encoder_queue.sv | 98 +++++++++
 rtl/rle_encoder.sv | 157 +++++++++++++++
 tb/tb_rle_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rle_encoder_pkg.sv
// Shared constants for the run-length encoder and its output queue.
package rle_encoder_pkg;

   localparam int RLE_DW     = 16;   // sample/word width, top bit is the tag
   localparam int RLE_CNTW   = 15;   // run-count field width
   localparam int RLE_QDEPTH = 4;    // output queue depth, power of 2
   localparam int RLE_SCNTW  = 25;   // emitted-word counter width

   localparam logic              RLE_TAG_DATA = 1'b0;
   localparam logic              RLE_TAG_CNT  = 1'b1;
   localparam logic [RLE_CNTW-1:0] RLE_CNT_MAX = 15'h7FFF;

   typedef logic [RLE_CNTW-1:0] rle_key_t;

endpackage

// File: rtl/rle_encoder_queue.sv
// Small synchronous FIFO with two ordered write ports and one read port.
// The output register is the first stage: a word pushed into an empty queue
// appears on dout at the same edge, so latency from push to dout is one cycle.
module rle_encoder_queue
   import rle_encoder_pkg::*;
#(
   parameter int DW     = RLE_DW,
   parameter int QDEPTH = RLE_QDEPTH
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          wr0_en,
   input  logic [DW-1:0] wr0_data,
   input  logic          wr1_en,
   input  logic [DW-1:0] wr1_data,
   output logic          dout_valid,
   output logic [DW-1:0] dout,
   output logic          drop
);

   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem [QDEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic          empty;
   logic          pop_mem;
   logic          load;
   logic          bypass0;
   logic          bypass1;
   logic          st0;
   logic          st1;
   logic          acc0;
   logic          acc1;
   logic [CW:0]   free;
   logic [1:0]    n_acc;
   logic          we0;
   logic          we1;
   logic [AW-1:0] wa0;
   logic [AW-1:0] wa1;
   logic [DW-1:0] wd0;
   logic [DW-1:0] wd1;

   // Decide which pushes bypass to dout, which are stored, and which are dropped.
   always_comb begin
      empty   = (count == '0);
      pop_mem = !empty;
      load    = pop_mem || wr0_en || wr1_en;
      bypass0 = empty && wr0_en;
      bypass1 = empty && !wr0_en && wr1_en;
      st0     = wr0_en && !bypass0;
      st1     = wr1_en && !bypass1;
      free    = (CW+1)'(QDEPTH) - {1'b0, count} + {{CW{1'b0}}, pop_mem};
      acc0    = st0 && (free != '0);
      acc1    = st1 && (free > {{CW{1'b0}}, acc0});
      drop    = (st0 && !acc0) || (st1 && !acc1);
      n_acc   = {1'b0, acc0} + {1'b0, acc1};
      we0     = acc0 || acc1;
      wa0     = wr_ptr;
      wd0     = acc0 ? wr0_data : wr1_data;
      we1     = acc0 && acc1;
      wa1     = wr_ptr + AW'(1);
      wd1     = wr1_data;
   end

   // Storage array, written in push order.
   always_ff @(posedge clk) begin
      if (we0) mem[wa0] <= wd0;
      if (we1) mem[wa1] <= wd1;
   end

   // Pointers, occupancy and the registered output word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
         dout       <= '0;
      end else if (clear) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= load;
         if (load) dout <= pop_mem ? mem[rd_ptr] : (wr0_en ? wr0_data : wr1_data);
         rd_ptr <= rd_ptr + AW'(pop_mem);
         wr_ptr <= wr_ptr + AW'(n_acc);
         count  <= count + CW'(n_acc) - CW'(pop_mem);
      end
   end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder: turns a 15-bit-key sample stream into tagged data/count
// words. A count word carries the number of extra repeats of the last data word;
// consecutive count words add. Words leave through a small ordered queue.
module rle_encoder
   import rle_encoder_pkg::*;
#(
   parameter int DW     = RLE_DW,
   parameter int CNTW   = RLE_CNTW,
   parameter int QDEPTH = RLE_QDEPTH,
   parameter int SCNTW  = RLE_SCNTW
)(
   input  logic             core_clk,
   input  logic             core_rst_n,
   input  logic             sample_en,
   input  logic             capture_valid,
   input  logic [DW-1:0]    capture_data,
   input  logic             capture_done,
   output logic             rle_valid,
   output logic [DW-1:0]    rle_data,
   output logic [SCNTW-1:0] rle_sample_cnt,
   output logic             rle_overflow
);

   localparam logic [CNTW-1:0] REP_LAST = {{(CNTW-1){1'b1}}, 1'b0};

   logic            sample_en_d;
   logic            restart;
   logic            accept;
   logic [CNTW-1:0] key;
   logic [CNTW-1:0] last_key;
   logic [CNTW-1:0] last_key_next;
   logic [CNTW-1:0] rep;
   logic [CNTW-1:0] rep_next;
   logic            last_valid;
   logic            last_valid_next;
   logic            done_seen;
   logic            done_seen_next;
   logic            wr0_en;
   logic            wr1_en;
   logic [DW-1:0]   wr0_data;
   logic [DW-1:0]   wr1_data;
   logic            q_drop;
   logic            unused_tag_bit;

   // The top sample bit carries no channel data in 15-channel mode.
   assign unused_tag_bit = capture_data[DW-1];

   assign restart = sample_en && !sample_en_d;
   assign accept  = capture_valid && !done_seen && !restart;
   assign key     = capture_data[CNTW-1:0];

   // Run tracking and word generation; the sample is handled before any flush.
   always_comb begin
      last_key_next   = last_key;
      rep_next        = rep;
      last_valid_next = last_valid;
      done_seen_next  = done_seen;
      wr0_en          = 1'b0;
      wr1_en          = 1'b0;
      wr0_data        = '0;
      wr1_data        = '0;
      if (accept) begin
         if (!last_valid) begin
            wr0_en          = 1'b1;
            wr0_data        = {RLE_TAG_DATA, key};
            last_key_next   = key;
            last_valid_next = 1'b1;
            rep_next        = '0;
         end else if (key != last_key) begin
            if (rep != '0) begin
               wr0_en   = 1'b1;
               wr0_data = {RLE_TAG_CNT, rep};
               wr1_en   = 1'b1;
               wr1_data = {RLE_TAG_DATA, key};
            end else begin
               wr0_en   = 1'b1;
               wr0_data = {RLE_TAG_DATA, key};
            end
            rep_next      = '0;
            last_key_next = key;
         end else if (rep == REP_LAST) begin
            // Run field would reach all-ones: emit a full count word and keep going.
            wr0_en   = 1'b1;
            wr0_data = {RLE_TAG_CNT, {CNTW{1'b1}}};
            rep_next = '0;
         end else begin
            rep_next = rep + CNTW'(1);
         end
      end
      // A pending repeat count only exists when the sample pushed nothing,
      // so the flush always finds port 0 free.
      if (capture_done && !done_seen && !restart) begin
         done_seen_next = 1'b1;
         if (rep_next != '0) begin
            wr0_en   = 1'b1;
            wr0_data = {RLE_TAG_CNT, rep_next};
            rep_next = '0;
         end
      end
   end

   // Encoder state with restart on the rising edge of sample_en.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         sample_en_d <= 1'b0;
         last_key    <= '0;
         rep         <= '0;
         last_valid  <= 1'b0;
         done_seen   <= 1'b0;
      end else begin
         sample_en_d <= sample_en;
         if (restart) begin
            last_key   <= '0;
            rep        <= '0;
            last_valid <= 1'b0;
            done_seen  <= 1'b0;
         end else begin
            last_key   <= last_key_next;
            rep        <= rep_next;
            last_valid <= last_valid_next;
            done_seen  <= done_seen_next;
         end
      end
   end

   // Emitted-word counter (saturating) and sticky overflow flag.
   always_ff @(posedge core_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         rle_sample_cnt <= '0;
         rle_overflow   <= 1'b0;
      end else if (restart) begin
         rle_sample_cnt <= '0;
         rle_overflow   <= 1'b0;
      end else begin
         if (rle_valid && (rle_sample_cnt != {SCNTW{1'b1}}))
            rle_sample_cnt <= rle_sample_cnt + SCNTW'(1);
         if (q_drop) rle_overflow <= 1'b1;
      end
   end

   rle_encoder_queue #(
      .DW     (DW),
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (core_clk),
      .rst_n      (core_rst_n),
      .clear      (restart),
      .wr0_en     (wr0_en),
      .wr0_data   (wr0_data),
      .wr1_en     (wr1_en),
      .wr1_data   (wr1_data),
      .dout_valid (rle_valid),
      .dout       (rle_data),
      .drop       (q_drop)
   );

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: a vector table for the per-cycle behaviour
// plus hand-written sequences for long runs, gaps, done and reset.
module tb_rle_encoder;

   logic        core_clk = 1'b0;
   logic        core_rst_n = 1'b0;
   logic        sample_en = 1'b0;
   logic        capture_valid = 1'b0;
   logic [15:0] capture_data = '0;
   logic        capture_done = 1'b0;
   logic        rle_valid;
   logic [15:0] rle_data;
   logic [24:0] rle_sample_cnt;
   logic        rle_overflow;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [15:0] got[$];

   typedef struct {
      logic        en;
      logic        v;
      logic [15:0] d;
      logic        done;
      logic        ev;
      logic [15:0] ed;
      logic        cc;
      logic [24:0] ec;
   } vec_t;

   vec_t tbl[$];

   rle_encoder dut (
      .core_clk       (core_clk),
      .core_rst_n     (core_rst_n),
      .sample_en      (sample_en),
      .capture_valid  (capture_valid),
      .capture_data   (capture_data),
      .capture_done   (capture_done),
      .rle_valid      (rle_valid),
      .rle_data       (rle_data),
      .rle_sample_cnt (rle_sample_cnt),
      .rle_overflow   (rle_overflow)
   );

   always #5 core_clk = ~core_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // One clock cycle of stimulus; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic en, input logic v, input logic [15:0] d, input logic done);
      sample_en     = en;
      capture_valid = v;
      capture_data  = d;
      capture_done  = done;
      @(posedge core_clk);
      #1;
      if (rle_valid) got.push_back(rle_data);
   endtask

   task automatic restart_enc();
      step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b0);
      got.delete();
   endtask

   task automatic check_got(input string name, input int idx, input logic [15:0] exp);
      logic [15:0] w;
      w = (idx < got.size()) ? got[idx] : 16'hDEAD;
      check($sformatf("%s[%0d]", name, idx), {16'h0, w}, {16'h0, exp});
   endtask

   function automatic vec_t mk(input logic en, input logic v, input logic [15:0] d,
                               input logic done, input logic ev, input logic [15:0] ed,
                               input logic cc = 1'b0, input logic [24:0] ec = '0);
      vec_t r;
      r.en = en; r.v = v; r.d = d; r.done = done;
      r.ev = ev; r.ed = ed; r.cc = cc; r.ec = ec;
      return r;
   endfunction

   initial begin
      // Prelude: arm, rising edge drops its own sample
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 1, 16'h0009, 0, 0, 16'h0000));
      // Run of five 0x0005 then one 0x0006, done
      tbl.push_back(mk(1, 1, 16'h0005, 0, 1, 16'h0005));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 1, 16'h0005, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 1, 16'h0006, 0, 1, 16'h8004));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h0006));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 1, 25'd3));
      // Alternating keys: one data word per cycle
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000));
      for (int i = 0; i < 8; i++) begin
         logic [15:0] k;
         k = (i % 2 == 0) ? 16'h0001 : 16'h0002;
         tbl.push_back(mk(1, 1, k, 0, 1, k));
      end
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000));
      // Bit 15 ignored; samples after done ignored
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 1, 16'h8001, 0, 1, 16'h0001));
      tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 1, 1, 16'h8001));
      tbl.push_back(mk(1, 1, 16'h0001, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000));
      // Restart with a word still queued
      tbl.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 1, 16'h0004, 0, 1, 16'h0004));
      tbl.push_back(mk(1, 1, 16'h0004, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 16'h0005, 0, 1, 16'h8001));
      tbl.push_back(mk(1, 1, 16'h0006, 0, 0, 16'h0000, 1, 25'd0));
      tbl.push_back(mk(1, 1, 16'h0005, 0, 1, 16'h0005));
      tbl.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000));

      // Reset held for three cycles
      repeat (3) @(posedge core_clk);
      #1;
      check("reset rle_valid", {31'h0, rle_valid}, 32'h0);
      check("reset rle_data", {16'h0, rle_data}, 32'h0);
      check("reset rle_sample_cnt", {7'h0, rle_sample_cnt}, 32'h0);
      check("reset rle_overflow", {31'h0, rle_overflow}, 32'h0);
      core_rst_n = 1'b1;

      // Table-driven portion
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].en, tbl[i].v, tbl[i].d, tbl[i].done);
         check($sformatf("vec%0d valid", i), {31'h0, rle_valid}, {31'h0, tbl[i].ev});
         if (tbl[i].ev)
            check($sformatf("vec%0d data", i), {16'h0, rle_data}, {16'h0, tbl[i].ed});
         if (tbl[i].cc)
            check($sformatf("vec%0d cnt", i), {7'h0, rle_sample_cnt}, {7'h0, tbl[i].ec});
      end
      check("table overflow", {31'h0, rle_overflow}, 32'h0);

      // Long run crossing the count-field limit
      restart_enc();
      for (int i = 0; i < 32770; i++) step(1'b1, 1'b1, 16'h0003, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0);
      check("longrun words", got.size(), 32'd3);
      check_got("longrun", 0, 16'h0003);
      check_got("longrun", 1, 16'hFFFF);
      check_got("longrun", 2, 16'h8002);
      check("longrun cnt", {7'h0, rle_sample_cnt}, 32'd3);
      check("longrun overflow", {31'h0, rle_overflow}, 32'h0);

      // Run with capture_valid gaps, done on the last sample
      restart_enc();
      step(1'b1, 1'b1, 16'h0007, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b1, 1'b1, 16'h0007, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b1, 1'b1, 16'h0007, 1'b0);
      step(1'b1, 1'b1, 16'h0007, 1'b1);
      repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
      check("gaps words", got.size(), 32'd2);
      check_got("gaps", 0, 16'h0007);
      check_got("gaps", 1, 16'h8003);
      got.delete();
      step(1'b1, 1'b1, 16'h0009, 1'b0);
      step(1'b1, 1'b1, 16'h0009, 1'b1);
      step(1'b1, 1'b1, 16'h000A, 1'b0);
      repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0);
      check("after done words", got.size(), 32'd0);
      restart_enc();
      step(1'b1, 1'b1, 16'h0009, 1'b0);
      check("rearm valid", {31'h0, rle_valid}, 32'h1);
      check("rearm data", {16'h0, rle_data}, 32'h0009);

      // Reset asserted mid-capture with a word still queued
      restart_enc();
      step(1'b1, 1'b1, 16'h0004, 1'b0);
      step(1'b1, 1'b1, 16'h0004, 1'b0);
      step(1'b1, 1'b1, 16'h0005, 1'b0);
      #2;
      core_rst_n = 1'b0;
      #1;
      check("midrst valid", {31'h0, rle_valid}, 32'h0);
      check("midrst data", {16'h0, rle_data}, 32'h0);
      check("midrst cnt", {7'h0, rle_sample_cnt}, 32'h0);
      @(negedge core_clk);
      core_rst_n = 1'b1;
      step(1'b1, 1'b0, 16'h0, 1'b0);
      check("postrst idle valid", {31'h0, rle_valid}, 32'h0);
      step(1'b1, 1'b1, 16'h0005, 1'b0);
      check("postrst valid", {31'h0, rle_valid}, 32'h1);
      check("postrst data", {16'h0, rle_data}, 32'h0005);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
